// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the lcd_draw_* family of
// panel drawing blocks.
package lcd_pkg;

    localparam int unsigned LCD_H_RES = 240;
    localparam int unsigned LCD_V_RES = 320;

    localparam logic [8:0] LCD_CMD_CASET = 9'h02A;
    localparam logic [8:0] LCD_CMD_RASET = 9'h02B;
    localparam logic [8:0] LCD_CMD_RAMWR = 9'h02C;

    localparam int unsigned WIN_WORDS = 11;

    typedef enum logic [1:0] {
        StIdle,
        StSetwin,
        StFill,
        StDone
    } lcd_state_e;

    function automatic logic [8:0] clamp9(input logic [8:0] v, input logic [8:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/lcd_set_window.sv
// Address-window sequencer: walks CASET/RASET/RAMWR and their coordinate bytes,
// one word per advance, presenting the current word combinationally.
module lcd_set_window
    import lcd_pkg::*;
#(
    parameter logic [8:0] CMD_CASET = LCD_CMD_CASET,
    parameter logic [8:0] CMD_RASET = LCD_CMD_RASET,
    parameter logic [8:0] CMD_RAMWR = LCD_CMD_RAMWR
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clear,
    input  logic        advance,
    input  logic [15:0] xa,
    input  logic [15:0] xb,
    input  logic [15:0] ya,
    input  logic [15:0] yb,
    output logic [8:0]  word,
    output logic        last
);

    logic [3:0] idx_q, idx_d;

    assign last = (idx_q == 4'(WIN_WORDS - 1));

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (advance && !last) begin
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        word = '0;
        case (idx_q)
            4'd0:    word = CMD_CASET;
            4'd1:    word = {1'b1, xa[15:8]};
            4'd2:    word = {1'b1, xa[7:0]};
            4'd3:    word = {1'b1, xb[15:8]};
            4'd4:    word = {1'b1, xb[7:0]};
            4'd5:    word = CMD_RASET;
            4'd6:    word = {1'b1, ya[15:8]};
            4'd7:    word = {1'b1, ya[7:0]};
            4'd8:    word = {1'b1, yb[15:8]};
            4'd9:    word = {1'b1, yb[7:0]};
            4'd10:   word = CMD_RAMWR;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/lcd_fill_rect.sv
// Fills a clamped, sorted rectangle with one RGB565 colour: sets the panel
// address window, then streams two bytes per pixel through the word handshake.
module lcd_fill_rect
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES     = LCD_H_RES,
    parameter int unsigned V_RES     = LCD_V_RES,
    parameter logic [8:0]  CMD_CASET = LCD_CMD_CASET,
    parameter logic [8:0]  CMD_RASET = LCD_CMD_RASET,
    parameter logic [8:0]  CMD_RAMWR = LCD_CMD_RAMWR
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  lcd_data,
    output logic        en_write,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] X_MAX = 9'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    lcd_state_e  state_q, state_d;
    logic [8:0]  xa_q, xb_q, ya_q, yb_q;
    logic [15:0] color_q;
    logic [17:0] cnt_q, cnt_d;

    logic        latch;
    logic        seq_clear;
    logic        seq_adv;
    logic [8:0]  seq_word;
    logic        seq_last;

    logic [8:0]  x_lo, x_hi, y_lo, y_hi;
    logic [9:0]  width, height;
    logic [19:0] npix;
    logic [20:0] nbytes;
    logic        fill_last;

    assign x_lo = (x0 < x1) ? x0 : x1;
    assign x_hi = (x0 < x1) ? x1 : x0;
    assign y_lo = (y0 < y1) ? y0 : y1;
    assign y_hi = (y0 < y1) ? y1 : y0;

    assign width     = {1'b0, xb_q} - {1'b0, xa_q} + 10'd1;
    assign height    = {1'b0, yb_q} - {1'b0, ya_q} + 10'd1;
    assign npix      = 20'(width) * 20'(height);
    assign nbytes    = {npix, 1'b0};
    assign fill_last = (({3'b000, cnt_q} + 21'd1) == nbytes);

    lcd_set_window #(
        .CMD_CASET (CMD_CASET),
        .CMD_RASET (CMD_RASET),
        .CMD_RAMWR (CMD_RAMWR)
    ) u_set_window (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (seq_clear),
        .advance   (seq_adv),
        .xa        ({7'd0, xa_q}),
        .xb        ({7'd0, xb_q}),
        .ya        ({7'd0, ya_q}),
        .yb        ({7'd0, yb_q}),
        .word      (seq_word),
        .last      (seq_last)
    );

    // abort is checked before wr_done so it wins when both arrive together
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        seq_clear = 1'b0;
        seq_adv   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    latch     = 1'b1;
                    seq_clear = 1'b1;
                    cnt_d     = '0;
                    state_d   = StSetwin;
                end
            end
            StSetwin: begin
                if (abort) begin
                    state_d = StDone;
                end else if (wr_done) begin
                    if (seq_last) begin
                        cnt_d   = '0;
                        state_d = StFill;
                    end else begin
                        seq_adv = 1'b1;
                    end
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StDone;
                end else if (wr_done) begin
                    if (fill_last) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 18'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            ya_q    <= '0;
            yb_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                xa_q    <= clamp9(x_lo, X_MAX);
                xb_q    <= clamp9(x_hi, X_MAX);
                ya_q    <= clamp9(y_lo, Y_MAX);
                yb_q    <= clamp9(y_hi, Y_MAX);
                color_q <= color;
            end
        end
    end

    // Even byte index carries the colour high byte, odd the low byte
    always_comb begin
        lcd_data = '0;
        case (state_q)
            StSetwin: lcd_data = seq_word;
            StFill:   lcd_data = cnt_q[0] ? {1'b1, color_q[7:0]} : {1'b1, color_q[15:8]};
            default:  lcd_data = '0;
        endcase
    end

    assign en_write = (state_q == StSetwin) || (state_q == StFill);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Scoreboard bench for lcd_fill_rect: expected words are queued at start and
// popped as the writer model acknowledges each word.
module tb_lcd_fill_rect;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic        abort;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic        wr_done;
    logic [8:0]  lcd_data;
    logic        en_write;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    lcd_fill_rect dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .abort     (abort),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .color     (color),
        .wr_done   (wr_done),
        .lcd_data  (lcd_data),
        .en_write  (en_write),
        .busy      (busy),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic push_rect(input int xa, input int xb, input int ya, input int yb,
                             input logic [15:0] c);
        logic [15:0] v;
        exp_q.push_back(9'h02A);
        v = 16'(xa); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
        v = 16'(xb); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
        exp_q.push_back(9'h02B);
        v = 16'(ya); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
        v = 16'(yb); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
        exp_q.push_back(9'h02C);
        for (int p = 0; p < (xb - xa + 1) * (yb - ya + 1); p++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    task automatic start_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                              input logic [15:0] c);
        @(negedge sys_clk);
        x0 = 9'(ax0); y0 = 9'(ay0); x1 = 9'(ax1); y1 = 9'(ay1);
        color = c;
        start = 1'b1;
    endtask

    // SPI writer model: acknowledges a word every gap+1 cycles while en_write is high
    task automatic run_writer(input int gap, input int max_words, input int budget,
                              input int poke_at, output int nwords);
        int   wait_c;
        int   cyc;
        bit   stop;
        logic [8:0] exp;
        nwords = 0; wait_c = 0; cyc = 0; stop = 0;
        while (!stop) begin
            @(negedge sys_clk);
            wr_done = 1'b0;
            start   = 1'b0;
            cyc++;
            if (cyc > budget) begin
                checks++; errors++;
                $display("FAIL writer_timeout: got %0d words, required completion within %0d cycles",
                         nwords, budget);
                stop = 1;
            end else if (en_write === 1'b1) begin
                if (wait_c >= gap) begin
                    wait_c = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL word_%0d: got %h, required no further word", nwords, lcd_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (lcd_data !== exp) begin
                            errors++;
                            $display("FAIL word_%0d: got %h, required %h", nwords, lcd_data, exp);
                        end
                    end
                    wr_done = 1'b1;
                    nwords++;
                    if (nwords == poke_at) begin
                        start = 1'b1;
                        x0 = 9'd0; x1 = 9'd100; y0 = 9'd0; y1 = 9'd100; color = 16'h1234;
                    end
                    if (nwords == max_words) stop = 1;
                end else begin
                    wait_c++;
                end
            end else if (busy === 1'b0) begin
                stop = 1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({lcd_data, en_write, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL %s: got data=%h en=%b busy=%b done=%b, required all zero",
                     tag, lcd_data, en_write, busy, done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        check_idle_outputs("reset_outputs");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        abort = 1'b1; wr_done = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0; wr_done = 1'b0;
        @(negedge sys_clk);
        check_idle_outputs("idle_ignores_abort_wr_done");
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL reset_done_count: got %0d, required 0", done_cnt);
        end
    endtask

    task automatic test_single_pixel();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.delete();
        exp_q = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105,
                  9'h02B, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02C, 9'h1F8, 9'h100};
        start_rect(5, 5, 5, 5, 16'hF800);
        @(negedge sys_clk);
        start = 1'b0;
        checks++;
        if (en_write !== 1'b1 || busy !== 1'b1 || lcd_data !== 9'h02A) begin
            errors++;
            $display("FAIL first_word_latency: got en=%b busy=%b data=%h, required 1 1 02a",
                     en_write, busy, lcd_data);
        end
        run_writer(3, 1000, 400, -1, n);
        checks++;
        if (n !== 13 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_pixel_words: got %0d (left %0d), required 13 (left 0)",
                     n, exp_q.size());
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_pixel_done: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_full_screen();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.delete();
        push_rect(0, 239, 0, 319, 16'h07E0);
        start_rect(0, 0, 239, 319, 16'h07E0);
        run_writer(0, 200000, 160000, -1, n);
        checks++;
        if (n - 11 !== 153600 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL full_screen_bytes: got %0d, required 153600", n - 11);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL full_screen_done: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_swapped_clamped();
        int n;
        exp_q.delete();
        push_rect(10, 200, 300, 319, 16'hABCD);
        start_rect(200, 300, 10, 400, 16'hABCD);
        run_writer(0, 20000, 10000, -1, n);
        checks++;
        if (n - 11 !== 7640 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL swapped_bytes: got %0d, required 7640", n - 11);
        end
    endtask

    task automatic test_start_mid_fill();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.delete();
        push_rect(3, 7, 2, 4, 16'h5A3C);
        start_rect(7, 4, 3, 2, 16'h5A3C);
        run_writer(1, 1000, 500, 20, n);
        checks++;
        if (n !== 41 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL start_mid_fill_words: got %0d, required 41", n);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL start_mid_fill_done: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.delete();
        push_rect(0, 49, 0, 9, 16'h00FF);
        start_rect(0, 0, 49, 9, 16'h00FF);
        run_writer(0, 111, 1000, -1, n);
        @(negedge sys_clk);
        abort = 1'b1; wr_done = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0; wr_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || en_write !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_to_done: got busy=%b en=%b done=%b, required 1 0 1",
                     busy, en_write, done);
        end
        @(negedge sys_clk);
        check_idle_outputs("abort_then_idle");
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses, required 1", done_cnt - d0);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_setwin();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.delete();
        push_rect(1, 2, 3, 4, 16'hC0DE);
        start_rect(1, 3, 2, 4, 16'hC0DE);
        run_writer(1, 3, 100, -1, n);
        @(negedge sys_clk);
        wr_done = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_setwin");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_idle_outputs("after_reset_release");
        checks++;
        if (done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        exp_q.delete();
        push_rect(1, 2, 3, 4, 16'hC0DE);
        start_rect(1, 3, 2, 4, 16'hC0DE);
        run_writer(2, 1000, 500, -1, n);
        checks++;
        if (n !== 19 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL restart_words: got %0d, required 19", n);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL restart_done: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; wr_done = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        test_reset();
        test_single_pixel();
        test_swapped_clamped();
        test_start_mid_fill();
        test_abort();
        test_reset_mid_setwin();
        test_full_screen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_fill_rect.md
LCD_FILL_RECT -- requirements
Module: lcd_fill_rect

Interface
REQ-001 Parameter H_RES, default 240, panel width in pixels.
REQ-002 Parameter V_RES, default 320, panel height in pixels.
REQ-003 Parameter CMD_CASET, default 9'h02A; CMD_RASET, default 9'h02B; CMD_RAMWR, default 9'h02C. Bit 8 = 0 marks a command.
REQ-004 sys_clk  in  1  clock.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request pulse, sampled only in IDLE.
REQ-007 abort  in  1  terminates the operation in progress.
REQ-008 x0, x1  in  9 each  column bounds, inclusive, any order.
REQ-009 y0, y1  in  9 each  row bounds, inclusive, any order.
REQ-010 color  in  16  RGB565 fill colour.
REQ-011 wr_done  in  1  one-cycle pulse from the SPI writer when the current word has been sent.
REQ-012 lcd_data  out  9  bit 8 = D/C (1 = data), bits 7:0 = payload.
REQ-013 en_write  out  1  high while words are to be sent.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on completion or abort.

Function
REQ-016 The state machine SHALL have four states, IDLE, SETWIN, FILL and DONE, with these transitions:
- IDLE -> SETWIN on start.
- SETWIN -> FILL after 11 words.
- FILL -> DONE after the last byte.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-017 On start in IDLE, the block SHALL latch sorted bounds (xa = min(x0,x1), xb = max, ya/yb likewise) and color. Bounds SHALL be clamped to H_RES-1 and V_RES-1 respectively.
REQ-018 A start pulse outside IDLE SHALL be ignored, and the latched values SHALL NOT change.
REQ-019 SETWIN SHALL present 11 words in this order, each a data word except where marked:
- CMD_CASET (command), {1,xa[15:8]}, {1,xa[7:0]}, {1,xb[15:8]}, {1,xb[7:0]}
- CMD_RASET (command), {1,ya hi}, {1,ya lo}, {1,yb hi}, {1,yb lo}
- CMD_RAMWR (command)
Coordinates SHALL be zero-extended to 16 bits.
REQ-020 FILL SHALL present (xb-xa+1)*(yb-ya+1) pixels, each as two words: {1,color[15:8]} then {1,color[7:0]}.
REQ-021 The byte counter SHALL be 18 bits wide, which covers 2*240*320 = 153600 bytes without wrap.
REQ-022 Word handshake: lcd_data SHALL be valid while en_write=1 and SHALL hold until wr_done. The next word SHALL appear on the cycle after wr_done.
REQ-023 A wr_done received outside SETWIN/FILL SHALL be ignored.
REQ-024 The first SETWIN word SHALL be valid on the cycle after start is accepted.
REQ-025 en_write SHALL deassert on the cycle after the wr_done of the final FILL byte.
REQ-026 done SHALL pulse for exactly 1 cycle, while the state is DONE.
REQ-027 abort in SETWIN or FILL SHALL force DONE on the next cycle, with en_write low from that cycle on. abort in IDLE or DONE SHALL have no effect.
REQ-028 If abort and wr_done occur in the same cycle, abort SHALL win.
REQ-029 Degenerate rectangles (xa=xb and/or ya=yb) SHALL be legal; a single pixel is 2 FILL bytes.

Reset
REQ-030 While sys_rst_n=0, all state SHALL clear asynchronously:
- state = IDLE
- lcd_data = 9'h000
- en_write = 0, busy = 0, done = 0
- all counters and latched bounds = 0
REQ-031 Reset asserted mid-FILL SHALL abandon the transfer with no done pulse. After release the block SHALL wait in IDLE.

Structure
REQ-032 The CMD_* values, H_RES/V_RES defaults and the state encoding SHALL reside in a shared package, lcd_pkg.
REQ-033 The 11-word window sequencer SHALL be one sub-module, lcd_set_window, which is reused by the other lcd_draw_* blocks.

Verification
REQ-034 Single pixel: start with (5,5,5,5), color 16'hF800, wr_done every 4 cycles.
- Required: 11 window words 02A,100,105,100,105,02B,100,105,100,105,02C, then 1F8,100.
- Required: one done pulse.
REQ-035 Full screen: (0,0,239,319) -> exactly 153600 FILL bytes followed by a done pulse.
REQ-036 Swapped and out-of-range bounds: (200,300,10,400) -> window xa=10, xb=200, ya=300, yb=319; FILL bytes = 2*191*20 = 7640.
REQ-037 A start pulse mid-FILL with different coordinates -> no change to the output sequence or the byte count.
REQ-038 abort after the 100th FILL byte -> next cycle state DONE, en_write=0, one done pulse, then IDLE.
REQ-039 Reset asserted mid-SETWIN -> all outputs 0 immediately, no done pulse. A new start after release produces the full sequence from word 1.
